// File: rtl/subleq_sequencer.sv
// Control sequencer for a SUBLEQ core. It fetches A/B/C, reads mem[A] and mem[B], writes
// mem[B]-mem[A] back to B, and branches to C when the result is <= 0.
module subleq_sequencer #(
    parameter int unsigned          WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0,
    parameter logic [WORD_SIZE-1:0] HALT_ADDR = '1
) (
    input  logic                 clk,
    input  logic                 areset_n,
    input  logic                 run,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    output logic [WORD_SIZE-1:0] pc,
    output logic                 instr_done,
    output logic                 halted
);
    localparam int unsigned W = WORD_SIZE;

    typedef enum logic [2:0] {
        S_FA   = 3'd0,
        S_FB   = 3'd1,
        S_FC   = 3'd2,
        S_RA   = 3'd3,
        S_RB   = 3'd4,
        S_EX   = 3'd5,
        S_HALT = 3'd6
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] c_q, c_d;
    logic [W-1:0] ma_q, ma_d;
    logic [W-1:0] result;
    logic         branch;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= S_FA;
            pc_q    <= RESET_PC;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            ma_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ma_q    <= ma_d;
        end
    end

    // Next state, register loads and memory-port decode.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        ma_d       = ma_q;
        mem_addr   = pc_q;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_wdata  = '0;
        instr_done = 1'b0;
        halted     = 1'b0;
        result     = mem_rdata - ma_q;
        branch     = result[W-1] | (result == '0);

        case (state_q)
            S_FA: begin
                mem_rd = run;
                if (run) begin
                    state_d = S_FB;
                end
            end
            S_FB: begin
                mem_addr = pc_q + W'(1);
                mem_rd   = 1'b1;
                a_d      = mem_rdata;
                state_d  = S_FC;
            end
            S_FC: begin
                mem_addr = pc_q + W'(2);
                mem_rd   = 1'b1;
                b_d      = mem_rdata;
                state_d  = S_RA;
            end
            S_RA: begin
                mem_addr = a_q;
                mem_rd   = 1'b1;
                c_d      = mem_rdata;
                state_d  = S_RB;
            end
            S_RB: begin
                mem_addr = b_q;
                mem_rd   = 1'b1;
                ma_d     = mem_rdata;
                state_d  = S_EX;
            end
            S_EX: begin
                mem_addr   = b_q;
                mem_wr     = 1'b1;
                mem_wdata  = result;
                instr_done = 1'b1;
                // Only a taken branch can halt; falling through onto HALT_ADDR keeps running.
                if (branch && (c_q == HALT_ADDR)) begin
                    pc_d    = c_q;
                    state_d = S_HALT;
                end else begin
                    pc_d    = branch ? c_q : (pc_q + W'(3));
                    state_d = S_FA;
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = S_FA;
            end
        endcase

        // Reset forces the port quiet at once, aborting any in-flight write.
        if (!areset_n) begin
            mem_addr   = RESET_PC;
            mem_rd     = 1'b0;
            mem_wr     = 1'b0;
            mem_wdata  = '0;
            instr_done = 1'b0;
            halted     = 1'b0;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_subleq_sequencer.sv
// Directed bench for subleq_sequencer: two instances (RESET_PC 0 and FFFD) on behavioural
// memories, with per-cycle port expectations queued and checked against the outputs.
module tb_subleq_sequencer;
    localparam int unsigned W = 16;

    logic         clk;
    logic         rst0_n, run0, rd0, wr0, done0, halt0;
    logic [W-1:0] rdata0, addr0, wdata0, pc0;
    logic         rst1_n, run1, rd1, wr1, done1, halt1;
    logic [W-1:0] rdata1, addr1, wdata1, pc1;

    logic         ld_en, ld_sel;
    logic [W-1:0] ld_addr, ld_data;
    logic [W-1:0] mem0 [65536];
    logic [W-1:0] mem1 [65536];

    logic         sel;
    int           n_tests;
    int           n_fail;
    string        tag_q[$];
    logic [35:0]  exp_q[$];

    subleq_sequencer #(
        .WORD_SIZE(16), .RESET_PC(16'h0000), .HALT_ADDR(16'hFFFF)
    ) dut (
        .clk(clk), .areset_n(rst0_n), .run(run0), .mem_rdata(rdata0),
        .mem_addr(addr0), .mem_rd(rd0), .mem_wr(wr0), .mem_wdata(wdata0),
        .pc(pc0), .instr_done(done0), .halted(halt0)
    );

    subleq_sequencer #(
        .WORD_SIZE(16), .RESET_PC(16'hFFFD), .HALT_ADDR(16'hFFFF)
    ) dut_w (
        .clk(clk), .areset_n(rst1_n), .run(run1), .mem_rdata(rdata1),
        .mem_addr(addr1), .mem_rd(rd1), .mem_wr(wr1), .mem_wdata(wdata1),
        .pc(pc1), .instr_done(done1), .halted(halt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memories with a bench-side load port.
    always @(posedge clk) begin
        if (ld_en && !ld_sel) mem0[ld_addr] <= ld_data;
        else if (wr0)         mem0[addr0]   <= wdata0;
        if (rd0)              rdata0        <= mem0[addr0];
        if (ld_en && ld_sel)  mem1[ld_addr] <= ld_data;
        else if (wr1)         mem1[addr1]   <= wdata1;
        if (rd1)              rdata1        <= mem1[addr1];
    end

    function automatic logic [35:0] mk(input logic [W-1:0] a, input logic rd, input logic wr,
                                       input logic [W-1:0] wd, input logic dn, input logic hl);
        return {a, rd, wr, wd, dn, hl};
    endfunction

    function automatic logic [35:0] obs();
        if (sel) return {addr1, rd1, wr1, wdata1, done1, halt1};
        return {addr0, rd0, wr0, wdata0, done0, halt0};
    endfunction

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [35:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic push_idle(input string tag, input logic [W-1:0] a, input int n);
        for (int i = 0; i < n; i++) push(tag, mk(a, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0));
    endtask

    task automatic push_instr(input string tag, input logic [W-1:0] p, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [W-1:0] wd);
        logic [W-1:0] p1;
        logic [W-1:0] p2;
        p1 = p + 16'd1;
        p2 = p + 16'd2;
        push({tag, "_fa"}, mk(p,  1'b1, 1'b0, 16'h0, 1'b0, 1'b0));
        push({tag, "_fb"}, mk(p1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0));
        push({tag, "_fc"}, mk(p2, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0));
        push({tag, "_ra"}, mk(a,  1'b1, 1'b0, 16'h0, 1'b0, 1'b0));
        push({tag, "_rb"}, mk(b,  1'b1, 1'b0, 16'h0, 1'b0, 1'b0));
        push({tag, "_ex"}, mk(b,  1'b0, 1'b1, wd,    1'b1, 1'b0));
    endtask

    task automatic check_now();
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL sb_underflow: observed output with no expectation queued");
        end else begin
            chk(tag_q.pop_front(), obs(), exp_q.pop_front());
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            check_now();
            @(negedge clk);
        end
    endtask

    task automatic load(input logic s, input logic [W-1:0] a, input logic [W-1:0] d);
        ld_sel  = s;
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic reset0();
        rst0_n = 1'b0;
        run0   = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        sel     = 1'b0;
        rst0_n  = 1'b0;
        rst1_n  = 1'b0;
        run0    = 1'b0;
        run1    = 1'b0;
        ld_en   = 1'b0;
        ld_sel  = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        @(negedge clk);

        // Reset and idle with run low
        load(1'b0, 16'd0, 16'd3);
        load(1'b0, 16'd1, 16'd4);
        load(1'b0, 16'd2, 16'd6);
        load(1'b0, 16'd3, 16'd5);
        load(1'b0, 16'd4, 16'd7);
        push("in_reset", mk(16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0));
        check_now();
        chk("pc_in_reset", {20'h0, pc0}, 36'h0);
        rst0_n = 1'b1;
        @(negedge clk);
        push_idle("idle_run0", 16'h0, 4);
        cycles(4);
        chk("pc_idle", {20'h0, pc0}, 36'h0);

        // Non-branch: 7-5=2 written to 4, pc advances by 3
        run0 = 1'b1;
        push_instr("nobr", 16'h0, 16'd3, 16'd4, 16'd2);
        cycles(6);
        run0 = 1'b0;
        chk("nobr_pc", {20'h0, pc0}, 36'h3);
        chk("nobr_mem4", {20'h0, mem0[4]}, 36'h2);
        push_idle("nobr_idle", 16'h3, 2);
        cycles(2);

        // Branch on zero
        reset0();
        load(1'b0, 16'd3, 16'd7);
        load(1'b0, 16'd4, 16'd7);
        rst0_n = 1'b1;
        run0   = 1'b1;
        push_instr("brz", 16'h0, 16'd3, 16'd4, 16'h0000);
        cycles(6);
        run0 = 1'b0;
        chk("brz_pc", {20'h0, pc0}, 36'h6);
        push_idle("brz_idle", 16'h6, 1);
        cycles(1);

        // Branch on negative: 7-9
        reset0();
        load(1'b0, 16'd3, 16'd9);
        load(1'b0, 16'd4, 16'd7);
        rst0_n = 1'b1;
        run0   = 1'b1;
        push_instr("brn", 16'h0, 16'd3, 16'd4, 16'hFFFE);
        cycles(6);
        run0 = 1'b0;
        chk("brn_pc", {20'h0, pc0}, 36'h6);
        chk("brn_mem4", {20'h0, mem0[4]}, 36'hFFFE);

        // Halt: A==B gives 0, taken branch to all-ones
        reset0();
        load(1'b0, 16'd0, 16'd3);
        load(1'b0, 16'd1, 16'd3);
        load(1'b0, 16'd2, 16'hFFFF);
        load(1'b0, 16'd3, 16'd5);
        rst0_n = 1'b1;
        run0   = 1'b1;
        push_instr("halt", 16'h0, 16'd3, 16'd3, 16'h0000);
        cycles(6);
        for (int i = 0; i < 22; i++) push("halted", mk(16'hFFFF, 1'b0, 1'b0, 16'h0, 1'b0, 1'b1));
        cycles(22);
        chk("halt_pc", {20'h0, pc0}, 36'hFFFF);
        chk("halt_mem3", {20'h0, mem0[3]}, 36'h0);

        // run dropped mid-instruction, then reset during a write
        reset0();
        load(1'b0, 16'd0, 16'd3);
        load(1'b0, 16'd1, 16'd4);
        load(1'b0, 16'd2, 16'd6);
        load(1'b0, 16'd3, 16'd5);
        load(1'b0, 16'd4, 16'd7);
        load(1'b0, 16'd5, 16'd1);
        rst0_n = 1'b1;
        run0   = 1'b1;
        push_instr("gate", 16'h0, 16'd3, 16'd4, 16'd2);
        cycles(2);
        run0 = 1'b0;
        cycles(4);
        push_idle("gate_idle", 16'h3, 3);
        cycles(3);
        chk("gate_pc", {20'h0, pc0}, 36'h3);
        run0 = 1'b1;
        // Second instruction: A=5, B=2 (mem[4] now 2), C=1; mem[2]-mem[5] = 6-1
        push_instr("gate2", 16'h3, 16'd5, 16'd2, 16'd5);
        cycles(5);
        check_now();
        rst0_n = 1'b0;
        run0   = 1'b0;
        push("rst_in_ex", mk(16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0));
        check_now();
        chk("rst_in_ex_pc", {20'h0, pc0}, 36'h0);
        @(negedge clk);
        chk("rst_in_ex_mem2", {20'h0, mem0[2]}, 36'h6);
        rst0_n = 1'b1;
        @(negedge clk);
        push_idle("post_rst_idle", 16'h0, 5);
        cycles(5);

        // PC wrap on the second instance
        sel = 1'b1;
        load(1'b1, 16'hFFFD, 16'd3);
        load(1'b1, 16'hFFFE, 16'd4);
        load(1'b1, 16'hFFFF, 16'd6);
        load(1'b1, 16'd3, 16'd5);
        load(1'b1, 16'd4, 16'd7);
        push("wrap_reset", mk(16'hFFFD, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0));
        check_now();
        chk("wrap_reset_pc", {20'h0, pc1}, 36'hFFFD);
        rst1_n = 1'b1;
        @(negedge clk);
        run1 = 1'b1;
        push_instr("wrap", 16'hFFFD, 16'd3, 16'd4, 16'd2);
        cycles(6);
        run1 = 1'b0;
        chk("wrap_pc", {20'h0, pc1}, 36'h0);
        push_idle("wrap_idle", 16'h0, 2);
        cycles(2);

        chk("sb_drained", 36'(exp_q.size()), 36'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
